// File: rtl/aes_block_packer.sv
// aes_block_packer
//   Input framing stage for a combinational AES-128 core. Collects WORD_W-bit
//   host words into 128-bit key and plaintext blocks, pairs each completed
//   plaintext block with the key held when its last word arrives, and offers
//   the pair on a one-entry valid/ready output buffer. The assembly register is
//   independent of the output buffer, so the next block is gathered while the
//   previous one waits.
//
// Ports
//   clk, rst      : single rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_kind : input word stream (s_kind 1 = key,
//                   0 = plaintext, sampled on the first word of a block only)
//   m_valid/m_ready : output block handshake
//   m_block, m_key  : plaintext block and its cipher key
//   key_valid       : a key block has been loaded since reset
//   err_nokey       : one-cycle pulse, plaintext block dropped for lack of key
module aes_block_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_kind,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [127:0]      m_block,
    output logic [127:0]      m_key,
    output logic              key_valid,
    output logic              err_nokey
);

    localparam int NWORDS = 128 / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t       state, state_nxt;
    logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
    logic             kind_lat, kind_lat_nxt;
    logic [127:0]     asm_reg, asm_nxt;
    logic [127:0]     key_reg, key_reg_nxt;
    logic             key_valid_nxt;
    logic [127:0]     m_block_nxt, m_key_nxt;
    logic             err_nxt;

    logic             is_last, cur_kind, accept, data_done, key_done, load;

    assign m_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            word_cnt  <= '0;
            kind_lat  <= 1'b0;
            asm_reg   <= '0;
            key_reg   <= '0;
            key_valid <= 1'b0;
            m_block   <= '0;
            m_key     <= '0;
            err_nokey <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            kind_lat  <= kind_lat_nxt;
            asm_reg   <= asm_nxt;
            key_reg   <= key_reg_nxt;
            key_valid <= key_valid_nxt;
            m_block   <= m_block_nxt;
            m_key     <= m_key_nxt;
            err_nokey <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        kind_lat_nxt  = kind_lat;
        asm_nxt       = asm_reg;
        key_reg_nxt   = key_reg;
        key_valid_nxt = key_valid;
        m_block_nxt   = m_block;
        m_key_nxt     = m_key;
        err_nxt       = 1'b0;

        is_last  = (word_cnt == LAST);
        cur_kind = (word_cnt == '0) ? s_kind : kind_lat;

        // Only the final word of a plaintext block can stall, and only when it
        // would need the output buffer while that buffer is still occupied.
        s_ready = !rst && !(is_last && !cur_kind && key_valid &&
                            (state == FULL) && !m_ready);

        accept    = s_valid && s_ready;
        data_done = accept && is_last && !cur_kind;
        key_done  = accept && is_last && cur_kind;
        load      = data_done && key_valid;

        if (accept) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                if (word_cnt == CNT_W'(i))
                    asm_nxt[127 - i*WORD_W -: WORD_W] = s_data;
            end
            word_cnt_nxt = is_last ? '0 : word_cnt + 1'b1;
            if (word_cnt == '0)
                kind_lat_nxt = s_kind;
        end

        // key_reg is read before its own update, so a block completing now
        // still pairs with the key that was current before this edge.
        if (key_done) begin
            key_reg_nxt   = asm_nxt;
            key_valid_nxt = 1'b1;
        end

        if (load) begin
            m_block_nxt = asm_nxt;
            m_key_nxt   = key_reg;
        end

        if (data_done && !key_valid)
            err_nxt = 1'b1;

        // A completion in the same cycle as an output handshake refills the
        // buffer, keeping the output at full throughput.
        if (load)
            state_nxt = FULL;
        else if (state == FULL && m_ready)
            state_nxt = EMPTY;
    end

endmodule
